axi_sram_slave: RTL and testbench

- AXI4-Lite responder: single-port word SRAM model with independent read and write channel FSMs.
- Sits on the far end of the CPU's AXI arbiter bus, answering AR/R and AW/W/B.
- Latency is configurable, so pipeline stalls and handshakes get exercised.
- Out-of-range accesses return SLVERR.

---
 rtl/axi_pkg.sv | 20 ++
 rtl/lfsr8.sv | 27 ++
 rtl/axi_sram_slave.sv | 271 +++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM responder.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {RIdle, RWait, RResp} rd_state_e;
  typedef enum logic [1:0] {WIdle, WWait, WResp} wr_state_e;

  // Widened to 34 bits so a window ending at the top of the 4 GiB space still compares correctly.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input logic [33:0] span_bytes);
    logic [33:0] off;
    off = {2'b00, addr} - {2'b00, base};
    return (addr >= base) && (off < span_bytes);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), free-running, seeded on reset.
module lfsr8
  import axi_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] out
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4-Lite word SRAM responder with independent read/write FSMs and configurable latency.
// Define AXI_SRAM_RAND_DELAY_EN to add 0-7 LFSR-driven extra wait cycles per transaction.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned WR_LAT      = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [33:0] SpanBytes = 34'(DEPTH_WORDS) << 2;

  typedef logic [IdxW-1:0] idx_t;

  function automatic idx_t word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return idx_t'(off >> 2);
  endfunction

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] rd_extra;
  logic [31:0] wr_extra;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_val;

  lfsr8 u_lfsr (
    .clock (clock),
    .reset (reset),
    .out   (lfsr_val)
  );

  assign rd_extra = {29'd0, lfsr_val[2:0]};
  assign wr_extra = {29'd0, lfsr_val[2:0]};
`else
  assign rd_extra = '0;
  assign wr_extra = '0;
`endif

  logic [31:0] rd_load;
  logic [31:0] wr_load;
  assign rd_load = 32'(RD_LAT - 1) + rd_extra;
  assign wr_load = 32'(WR_LAT - 1) + wr_extra;

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rd_state_e   rd_state_q;
  logic [31:0] rd_cnt_q;
  idx_t        rd_idx_q;
  logic        rd_ok_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic ar_hs;
  logic rd_fire;
  idx_t rd_src_idx;
  logic rd_src_ok;

  assign ar_hs = arvalid & arready_q;

  always_comb begin
    rd_fire    = 1'b0;
    rd_src_idx = rd_idx_q;
    rd_src_ok  = rd_ok_q;
    if (rd_state_q == RIdle) begin
      rd_src_idx = word_idx(araddr);
      rd_src_ok  = addr_in_range(araddr, BASE_ADDR, SpanBytes);
      rd_fire    = ar_hs && (rd_load == 32'd0);
    end else if (rd_state_q == RWait) begin
      rd_fire = (rd_cnt_q == 32'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= RIdle;
      rd_cnt_q   <= '0;
      rd_idx_q   <= '0;
      rd_ok_q    <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      unique case (rd_state_q)
        RIdle: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q  <= 1'b0;
            rd_idx_q   <= rd_src_idx;
            rd_ok_q    <= rd_src_ok;
            rd_cnt_q   <= rd_load;
            rd_state_q <= (rd_load == 32'd0) ? RResp : RWait;
          end
        end
        RWait: begin
          if (rd_cnt_q == 32'd1) begin
            rd_state_q <= RResp;
          end else begin
            rd_cnt_q <= rd_cnt_q - 32'd1;
          end
        end
        RResp: begin
          if (rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= RIdle;
          end
        end
        default: rd_state_q <= RIdle;
      endcase
      // Data is captured once, on the rising edge of rvalid, and held until the handshake.
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_src_ok ? mem_q[rd_src_idx] : 32'd0;
        rresp_q  <= rd_src_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  wr_state_e   wr_state_q;
  logic [31:0] wr_cnt_q;
  logic        aw_have_q;
  logic        w_have_q;
  idx_t        wr_idx_q;
  logic        wr_ok_q;
  logic [31:0] wr_data_q;
  logic [3:0]  wr_strb_q;
  logic        awready_q;
  logic        wready_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;

  logic        aw_hs;
  logic        w_hs;
  logic        both_now;
  logic        wr_fire;
  idx_t        wr_idx_eff;
  logic        wr_ok_eff;
  logic [31:0] wr_data_eff;
  logic [3:0]  wr_strb_eff;

  assign aw_hs       = awvalid & awready_q;
  assign w_hs        = wvalid & wready_q;
  assign wr_idx_eff  = aw_hs ? word_idx(awaddr) : wr_idx_q;
  assign wr_ok_eff   = aw_hs ? addr_in_range(awaddr, BASE_ADDR, SpanBytes) : wr_ok_q;
  assign wr_data_eff = w_hs ? wdata : wr_data_q;
  assign wr_strb_eff = w_hs ? wstrb : wr_strb_q;

  always_comb begin
    both_now = 1'b0;
    wr_fire  = 1'b0;
    if (wr_state_q == WIdle) begin
      both_now = (aw_have_q | aw_hs) & (w_have_q | w_hs);
      wr_fire  = both_now && (wr_load == 32'd0);
    end else if (wr_state_q == WWait) begin
      wr_fire = (wr_cnt_q == 32'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= WIdle;
      wr_cnt_q   <= '0;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      wr_idx_q   <= '0;
      wr_ok_q    <= 1'b0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      unique case (wr_state_q)
        WIdle: begin
          if (aw_hs) begin
            aw_have_q <= 1'b1;
            wr_idx_q  <= wr_idx_eff;
            wr_ok_q   <= wr_ok_eff;
          end
          if (w_hs) begin
            w_have_q  <= 1'b1;
            wr_data_q <= wdata;
            wr_strb_q <= wstrb;
          end
          awready_q <= ~(aw_have_q | aw_hs);
          wready_q  <= ~(w_have_q | w_hs);
          if (both_now) begin
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            wr_cnt_q   <= wr_load;
            wr_state_q <= (wr_load == 32'd0) ? WResp : WWait;
          end
        end
        WWait: begin
          if (wr_cnt_q == 32'd1) begin
            wr_state_q <= WResp;
          end else begin
            wr_cnt_q <= wr_cnt_q - 32'd1;
          end
        end
        WResp: begin
          if (bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= WIdle;
          end
        end
        default: wr_state_q <= WIdle;
      endcase
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok_eff ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Commit coincides with bvalid rising; reset suppresses it so aborted writes never land.
  always_ff @(posedge clock) begin
    if (!reset && wr_fire && wr_ok_eff) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_eff[b]) begin
          mem_q[wr_idx_eff][8*b +: 8] <= wr_data_eff[8*b +: 8];
        end
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: transaction-level model plus directed literal checks.
module tb_axi_sram_slave;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned RDL   = 1;
  localparam int unsigned WRL   = 3;

  logic        clock;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  axi_sram_slave #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .RD_LAT      (RDL),
    .WR_LAT      (WRL)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] mem_m [int unsigned];
  int unsigned e_cnt = 0;
  bit          m_live = 0;
  logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;
  bit          m_rdata_known, m_bresp_known;
  bit          r_busy, w_busy, w_have_aw, w_have_w;
  int unsigned r_due, w_due;
  logic [31:0] r_addr, w_addr, w_data;
  logic [3:0]  w_strb;

  function automatic bit in_rng(input logic [31:0] a);
    logic [63:0] a64;
    a64 = {32'd0, a};
    return (a64 >= {32'd0, BASE}) && (a64 < {32'd0, BASE} + 64'(4 * DEPTH));
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a - BASE) >> 2;
  endfunction

  task automatic model_step();
    int unsigned i;
    logic [31:0] old;
    e_cnt++;
    if (reset) begin
      m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
      m_rdata = '0; m_rresp = 2'b00; m_bresp = 2'b00;
      m_rdata_known = 1; m_bresp_known = 1;
      r_busy = 0; w_busy = 0; w_have_aw = 0; w_have_w = 0;
    end else begin
      // read side: sampled before any same-edge write commit, so it sees old data
      if (m_rvalid && rready) begin
        m_rvalid = 0; r_busy = 0; m_rdata_known = 0;
      end else if (!r_busy && arvalid && m_arready) begin
        r_busy = 1; r_addr = araddr; r_due = e_cnt + RDL - 1;
      end
      if (r_busy && !m_rvalid && e_cnt == r_due) begin
        m_rvalid = 1;
        if (in_rng(r_addr)) begin
          i = widx(r_addr);
          m_rdata_known = mem_m.exists(i);
          m_rdata = m_rdata_known ? mem_m[i] : '0;
          m_rresp = 2'b00;
        end else begin
          m_rdata_known = 1; m_rdata = '0; m_rresp = 2'b10;
        end
      end
      m_arready = !r_busy;
      // write side
      if (m_bvalid && bready) begin
        m_bvalid = 0; w_busy = 0; w_have_aw = 0; w_have_w = 0; m_bresp_known = 0;
      end else if (!w_busy) begin
        if (awvalid && m_awready) begin w_have_aw = 1; w_addr = awaddr; end
        if (wvalid && m_wready) begin w_have_w = 1; w_data = wdata; w_strb = wstrb; end
        if (w_have_aw && w_have_w) begin w_busy = 1; w_due = e_cnt + WRL - 1; end
      end
      if (w_busy && !m_bvalid && e_cnt == w_due) begin
        m_bvalid = 1; m_bresp_known = 1;
        m_bresp = in_rng(w_addr) ? 2'b00 : 2'b10;
        if (in_rng(w_addr)) begin
          i = widx(w_addr);
          old = mem_m.exists(i) ? mem_m[i] : '0;
          for (int b = 0; b < 4; b++) if (w_strb[b]) old[8*b +: 8] = w_data[8*b +: 8];
          mem_m[i] = old;
        end
      end
      m_awready = !w_busy && !w_have_aw;
      m_wready  = !w_busy && !w_have_w;
    end
    m_live = 1;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Per-cycle comparison against the model, well clear of the active edge.
  initial forever begin
    @(posedge clock);
    #4;
    if (m_live) begin
      chk("arready", {31'd0, arready}, {31'd0, m_arready});
      chk("rvalid",  {31'd0, rvalid},  {31'd0, m_rvalid});
      chk("awready", {31'd0, awready}, {31'd0, m_awready});
      chk("wready",  {31'd0, wready},  {31'd0, m_wready});
      chk("bvalid",  {31'd0, bvalid},  {31'd0, m_bvalid});
      if (m_rdata_known) begin
        chk("rdata", rdata, m_rdata);
        chk("rresp", {30'd0, rresp}, {30'd0, m_rresp});
      end
      if (m_bresp_known) chk("bresp", {30'd0, bresp}, {30'd0, m_bresp});
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_start, input int w_start,
                           output logic [1:0] resp, output int aw_k, output int w_k,
                           output int b_k);
    int k = 0;
    bit aw_done = 0, w_done = 0, fin = 0;
    aw_k = -1; w_k = -1; b_k = -1; resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s;
    while (!fin) begin
      awvalid = !aw_done && (k >= aw_start);
      wvalid  = !w_done && (k >= w_start);
      bready  = 1'b1;
      if (awvalid && awready) begin aw_done = 1; aw_k = k; end
      if (wvalid && wready) begin w_done = 1; w_k = k; end
      if (bvalid && bready) begin resp = bresp; b_k = k; fin = 1; end
      tick();
      k++;
      if (!fin && k > 200) begin timeout("write"); fin = 1; end
    end
    awvalid = 0; wvalid = 0; bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                          output logic [1:0] resp, output int ar_k, output int r_k);
    int k = 0, seen = 0;
    bit ar_done = 0, fin = 0;
    logic [31:0] first;
    ar_k = -1; r_k = -1; d = 'x; resp = 2'bxx; first = '0;
    araddr = a;
    while (!fin) begin
      arvalid = !ar_done;
      rready  = 1'b0;
      if (rvalid) begin
        if (seen == 0) begin
          r_k = k; first = rdata;
        end else begin
          chk("rdata_hold", rdata, first);
          chk("arready_low_in_resp", {31'd0, arready}, 32'd0);
        end
        rready = (seen >= hold);
        seen++;
      end
      if (arvalid && arready) begin ar_done = 1; ar_k = k; end
      if (rvalid && rready) begin d = rdata; resp = rresp; fin = 1; end
      tick();
      k++;
      if (!fin && k > 200) begin timeout("read"); fin = 1; end
    end
    arvalid = 0; rready = 0;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  logic [1:0]  rsp, bsp;
  int          ak, rk, wk, bk;
  logic [31:0] rd2;
  logic [1:0]  rsp2, bsp2;
  int          ak2, rk2, wk2, bk2, awk2;

  initial begin
    reset = 1; araddr = '0; arvalid = 0; rready = 0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    repeat (3) tick();
    reset = 0;
    chk("arready_in_reset", {31'd0, arready}, 32'd0);
    chk("bvalid_in_reset", {31'd0, bvalid}, 32'd0);
    tick();
    chk("arready_after_reset", {31'd0, arready}, 32'd1);
    chk("awready_after_reset", {31'd0, awready}, 32'd1);
    chk("wready_after_reset", {31'd0, wready}, 32'd1);

    // Basic write then read
    axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, bsp, ak, wk, bk);
    chk("wr1_bresp", {30'd0, bsp}, 32'd0);
    axi_read(32'h8000_0010, 0, rd, rsp, ak, rk);
    chk("rd1_data", rd, 32'hDEAD_BEEF);
    chk("rd1_resp", {30'd0, rsp}, 32'd0);
    chk("rd1_latency", 32'(rk - ak), 32'd1);

    // W three cycles ahead of AW
    axi_write(32'h8000_0020, 32'h1122_3344, 4'hF, 3, 0, bsp, ak, wk, bk);
    chk("wlead_w_cycle", 32'(wk), 32'd0);
    chk("wlead_aw_cycle", 32'(ak), 32'd3);
    chk("wlead_b_latency", 32'(bk - ak), 32'(WRL));

    // Partial write, AW ahead of W
    axi_write(32'h8000_0020, 32'h0000_AB00, 4'b0010, 0, 2, bsp, ak, wk, bk);
    chk("partial_bresp", {30'd0, bsp}, 32'd0);
    axi_read(32'h8000_0020, 0, rd, rsp, ak, rk);
    chk("partial_data", rd, 32'h1122_AB44);

    // Out of range on both channels; the aliased low word must not change
    axi_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, 0, 0, bsp, ak, wk, bk);
    axi_read(32'h7FFF_FFFC, 0, rd, rsp, ak, rk);
    chk("oor_rd_resp", {30'd0, rsp}, 32'd2);
    chk("oor_rd_data", rd, 32'd0);
    axi_write(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 0, 0, bsp, ak, wk, bk);
    chk("oor_wr_resp", {30'd0, bsp}, 32'd2);
    axi_read(32'h8000_0000, 0, rd, rsp, ak, rk);
    chk("oor_mem_unchanged", rd, 32'h0BAD_F00D);

    // Back-pressure on R, then an immediate follow-on AR
    axi_read(32'h8000_0010, 5, rd, rsp, ak, rk);
    chk("hold_data", rd, 32'hDEAD_BEEF);
    axi_read(32'h8000_0020, 0, rd, rsp, ak, rk);
    chk("b2b_ar_cycle", 32'(ak), 32'd0);
    chk("b2b_data", rd, 32'h1122_AB44);

    // Concurrent read and write on different words
    fork
      axi_write(32'h8000_0030, 32'hCAFE_0123, 4'hF, 1, 0, bsp2, awk2, wk2, bk2);
      axi_read(32'h8000_0010, 2, rd2, rsp2, ak2, rk2);
    join
    chk("conc_bresp", {30'd0, bsp2}, 32'd0);
    chk("conc_rdata", rd2, 32'hDEAD_BEEF);
    axi_read(32'h8000_0030, 0, rd, rsp, ak, rk);
    chk("conc_readback", rd, 32'hCAFE_0123);

    // Reset while the write is waiting: nothing commits
    awaddr = 32'h8000_0010; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    tick();
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready", {31'd0, wready}, 32'd1);
    axi_read(32'h8000_0010, 0, rd, rsp, ak, rk);
    chk("rst_no_commit", rd, 32'hDEAD_BEEF);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
